// File: rtl/op_fetch.sv
// op_fetch: instruction fetch stage in front of the opram program store.
// An epoch-tagged return pipe hides RAM latency; a FWFT queue feeds decode.
module op_fetch #(
    parameter int                ADDR_W     = 8,
    parameter int                DATA_W     = 8,
    parameter int                RAM_LAT    = 2,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [DATA_W-1:0] HALT_OP    = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_ce,
    output logic              ram_oce,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] op_out,
    output logic [ADDR_W-1:0] op_pc,
    output logic              op_valid,
    input  logic              op_ready,
    output logic              halted,
    output logic              busy
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              epoch_q, epoch_d;

    logic              pv_q [RAM_LAT];
    logic              pe_q [RAM_LAT];
    logic [ADDR_W-1:0] pp_q [RAM_LAT];

    logic [DATA_W-1:0] fd_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] fp_q [FIFO_DEPTH];
    logic [PW-1:0]     rd_q, wr_q;
    logic [CW-1:0]     cnt_q;

    logic        fetching, pop, halt_pop, jump, go;
    logic        issue, push, flush;
    int unsigned occ;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Queued plus in-flight reads bound the queue, so a push never overflows.
    always_comb begin
        occ = 32'(cnt_q);
        for (int i = 0; i < RAM_LAT; i++) begin
            occ = occ + 32'(pv_q[i]);
        end
    end

    assign fetching = (state_q == FETCH);
    assign pop      = op_valid & op_ready;
    assign halt_pop = fetching & pop & (op_out == HALT_OP);
    assign jump     = fetching & jump_en & ~halt_pop;
    assign go       = start & ~fetching;
    assign issue    = fetching & ~jump & ~halt_pop
                    & (occ < 32'(FIFO_DEPTH));
    assign push     = fetching & pv_q[RAM_LAT-1]
                    & (pe_q[RAM_LAT-1] == epoch_q);
    assign flush    = go | jump | halt_pop;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epoch_d = epoch_q;
        unique case (state_q)
            FETCH: begin
                if (halt_pop) begin
                    state_d = HALTED;
                    epoch_d = ~epoch_q;
                end else if (jump) begin
                    pc_d    = jump_addr;
                    epoch_d = ~epoch_q;
                end else if (issue) begin
                    pc_d = pc_q + ADDR_W'(1);
                end
            end
            default: begin
                if (start) begin
                    state_d = FETCH;
                    pc_d    = start_addr;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            epoch_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epoch_q <= epoch_d;
        end
    end

    // A restart drops whatever is still travelling through the RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RAM_LAT; i++) begin
                pv_q[i] <= 1'b0;
                pe_q[i] <= 1'b0;
                pp_q[i] <= '0;
            end
        end else begin
            pv_q[0] <= issue;
            pe_q[0] <= epoch_q;
            pp_q[0] <= pc_q;
            for (int i = 1; i < RAM_LAT; i++) begin
                pv_q[i] <= pv_q[i-1] & ~go;
                pe_q[i] <= pe_q[i-1];
                pp_q[i] <= pp_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fd_q[i] <= '0;
                fp_q[i] <= '0;
            end
        end else if (flush) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                fd_q[wr_q] <= ram_dout;
                fp_q[wr_q] <= pp_q[RAM_LAT-1];
                wr_q       <= nxt(wr_q);
            end
            if (pop) begin
                rd_q <= nxt(rd_q);
            end
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    assign ram_addr = pc_q;
    assign ram_ce   = issue;
    assign ram_oce  = fetching;
    assign op_valid = (cnt_q != '0);
    assign op_out   = fd_q[rd_q];
    assign op_pc    = fp_q[rd_q];
    assign halted   = (state_q == HALTED);
    assign busy     = fetching;

endmodule

// File: tb/tb_op_fetch.sv
// tb_op_fetch: cycle tables for fixed programs plus a random
// scoreboard that predicts the delivered op stream from program order.
module tb_op_fetch;
    localparam logic [7:0] HALT = 8'hFF;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, jump_en = 1'b0, op_ready = 1'b0;
    logic [7:0] start_addr = 8'h00, jump_addr = 8'h00;
    logic [7:0] ram_addr, ram_dout, op_out, op_pc;
    logic       ram_ce, ram_oce, op_valid, halted, busy;

    int checks = 0;
    int failures = 0;

    logic [7:0] mem [256];
    logic [7:0] a_q, d_q;

    typedef struct {
        logic       rdy;
        logic       vld;
        logic [7:0] op;
        logic [7:0] pc;
        logic       hlt;
        logic       bsy;
    } vec_t;
    vec_t tbl [14];

    logic       m_act, hpend, stall;
    logic [7:0] e_pc, s_out, s_pc;
    logic [7:0] got [$];

    int max_occ = 0;
    int full_push = 0;
    int occ_now;

    op_fetch dut (
        .clk(clk), .rst(rst),
        .start(start), .start_addr(start_addr),
        .jump_en(jump_en), .jump_addr(jump_addr),
        .ram_addr(ram_addr), .ram_ce(ram_ce), .ram_oce(ram_oce),
        .ram_dout(ram_dout),
        .op_out(op_out), .op_pc(op_pc), .op_valid(op_valid),
        .op_ready(op_ready), .halted(halted), .busy(busy)
    );

    always #5 clk = ~clk;

    // opram: address register on ce, output register on oce
    always @(posedge clk) begin
        if (ram_ce) a_q <= ram_addr;
        if (ram_oce) d_q <= mem[a_q];
    end
    assign ram_dout = d_q;

    assign occ_now = int'(dut.cnt_q) + int'(dut.pv_q[0])
                   + int'(dut.pv_q[1]);
    always @(negedge clk) begin
        if (occ_now > max_occ) max_occ <= occ_now;
        if (dut.push && int'(dut.cnt_q) == 4 && !dut.flush)
            full_push <= full_push + 1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic rdy, input logic jmp,
                       input logic [7:0] ja, input logic st,
                       input logic [7:0] sa);
        @(negedge clk);
        op_ready = rdy; jump_en = jmp; jump_addr = ja;
        start = st; start_addr = sa;
        #1;
    endtask

    // Expected stream: program order from the start address, wrapping
    // mod 256, redirected by accepted jumps, ending at the halt opcode.
    task automatic sb(input logic rdy, input logic jmp,
                      input logic [7:0] ja, input logic st,
                      input logic [7:0] sa);
        logic hs, hp;
        cyc(rdy, jmp, ja, st, sa);
        if (hpend) begin
            chk("halt_state", {halted, busy, op_valid}, 3'b100);
            m_act = 1'b0;
            hpend = 1'b0;
        end else if (!m_act) begin
            chk("no_valid_halted", op_valid, 1'b0);
        end
        if (stall)
            chk("stall_stable", {op_valid, op_out, op_pc},
                {1'b1, s_out, s_pc});
        stall = 1'b0;
        hs = op_valid & rdy;
        hp = 1'b0;
        if (hs) begin
            chk("pop_pc", op_pc, e_pc);
            chk("pop_op", op_out, mem[e_pc]);
            got.push_back(op_pc);
            hp = m_act && (mem[e_pc] == HALT);
            if (hp) hpend = 1'b1;
            e_pc = e_pc + 8'd1;
        end
        if (op_valid && !rdy && !(jmp && m_act)) begin
            stall = 1'b1;
            s_out = mem[e_pc];
            s_pc  = e_pc;
        end
        if (jmp && m_act && !hp) e_pc = ja;
    endtask

    // mode 0: always ready; 1: random ready/jumps/starts; 2: ready 1-0-0-1
    task automatic episode(input logic [7:0] sa, input int mode,
                           input int maxc);
        logic       r, j, s;
        logic [7:0] ja;
        cyc(1'b0, 1'b0, 8'h00, 1'b1, sa);
        m_act = 1'b1; hpend = 1'b0; stall = 1'b0; e_pc = sa;
        got.delete();
        for (int c = 0; c < maxc; c++) begin
            if (!m_act && !hpend) break;
            r = 1'b1; j = 1'b0; s = 1'b0;
            ja = 8'($urandom_range(0, 255));
            if (mode == 2) r = (c % 4 == 0) || (c % 4 == 3);
            if (mode == 1) begin
                r = 1'($urandom_range(0, 1));
                j = (c < 60) && ($urandom_range(0, 11) == 0);
                s = (c < 60) && ($urandom_range(0, 19) == 0);
                if (c == 60) begin j = 1'b1; ja = 8'hBE; end
            end
            sb(r, j, ja, s && m_act, 8'($urandom_range(0, 255)));
        end
        chk("episode_ends_halted", {m_act, hpend, halted}, 3'b001);
    endtask

    task automatic load_linear();
        for (int i = 0; i < 256; i++) mem[i] = 8'h5A;
        for (int i = 0; i < 8; i++) mem[i] = 8'(i + 'h10);
        mem[8] = HALT;
        mem[8'h20] = 8'hA5;
        mem[8'h21] = HALT;
    endtask

    task automatic run_table(input string tag);
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 8'h00);
        for (int r = 0; r < 14; r++) begin
            cyc(tbl[r].rdy, 1'b0, 8'h00, 1'b0, 8'h00);
            chk($sformatf("%s%0d_vld", tag, r), op_valid, tbl[r].vld);
            if (tbl[r].vld) begin
                chk($sformatf("%s%0d_op", tag, r), op_out, tbl[r].op);
                chk($sformatf("%s%0d_pc", tag, r), op_pc, tbl[r].pc);
            end
            chk($sformatf("%s%0d_hb", tag, r), {halted, busy},
                {tbl[r].hlt, tbl[r].bsy});
        end
    endtask

    initial begin
        for (int r = 0; r < 14; r++) begin
            tbl[r].rdy = 1'b1;
            tbl[r].vld = (r >= 3) && (r <= 11);
            tbl[r].op  = (r == 11) ? HALT : 8'(r - 3 + 'h10);
            tbl[r].pc  = 8'(r - 3);
            tbl[r].hlt = (r >= 12);
            tbl[r].bsy = (r <= 11);
        end

        #2 rst = 1'b0;
        #1;
        chk("reset_vals", {ram_addr, ram_ce, ram_oce, op_out, op_pc,
                           op_valid, halted, busy}, 32'h0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;

        for (int c = 0; c < 20; c++) begin
            cyc(1'b1, 1'(c % 2), 8'h40, 1'b0, 8'h00);
            chk("idle_quiet", {op_valid, ram_ce, halted, busy}, 4'b0);
        end

        load_linear();
        run_table("lin");

        episode(8'h00, 2, 200);
        chk("bp_count", got.size(), 9);

        cyc(1'b1, 1'b0, 8'h00, 1'b1, 8'h00);
        for (int r = 0; r <= 10; r++) begin
            cyc(1'b1, r == 4, 8'h20, 1'b0, 8'h00);
            if (r == 3) chk("jmp_pc0", {op_valid, op_pc}, {1'b1, 8'h00});
            if (r == 4) chk("jmp_same_pop", {op_valid, op_pc}, {1'b1, 8'h01});
            if (r >= 5 && r <= 7) chk("jmp_gap", op_valid, 1'b0);
            if (r == 8) chk("jmp_target", {op_valid, op_out, op_pc},
                            {1'b1, 8'hA5, 8'h20});
            if (r == 9) chk("jmp_next", {op_valid, op_pc}, {1'b1, 8'h21});
            if (r == 10) chk("jmp_halted", {halted, op_valid}, 2'b10);
        end

        mem[8'hFE] = 8'h01; mem[8'hFF] = 8'h02;
        mem[8'h00] = 8'h03; mem[8'h01] = HALT;
        episode(8'hFE, 0, 50);
        chk("wrap_count", got.size(), 4);
        if (got.size() >= 3)
            chk("wrap_seq", {got[0], got[1], got[2]}, 24'hFEFF00);

        for (int e = 0; e < 3; e++) begin
            for (int i = 0; i < 256; i++)
                mem[i] = 8'($urandom_range(0, 254));
            mem[8'hC0] = HALT;
            episode(8'($urandom_range(0, 255)), 1, 300);
        end

        load_linear();
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 8'h00);
        repeat (5) cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        chk("pre_reset_busy", {busy, op_valid}, 2'b11);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_reset", {op_valid, ram_ce, busy, halted}, 4'b0);
        @(negedge clk);
        rst = 1'b1;
        run_table("rst");

        chk("occ_max_le4", max_occ <= 4, 1'b1);
        chk("no_full_push", full_push, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/op_fetch.md
Name: op_fetch

Overview:
- Instruction fetch stage sitting directly downstream of the opram program store.
- Drives the opram read address and enables and captures returned opcodes. It compensates for the fixed RAM read latency.
- Presents opcodes to the decode stage over a valid/ready handshake.
- Supports start, jump (with flush of in-flight reads) and halt-on-opcode.

Parameters:
- ADDR_W, 8, program-counter and RAM address width.
- DATA_W, 8, opcode width.
- RAM_LAT, 2, cycles from ram_addr sample to valid ram_dout (address register plus output register with oce=1).
- FIFO_DEPTH, 4, output queue entries; must be >= RAM_LAT.
- HALT_OP, 8'hFF, opcode that stops fetching once consumed.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  1-cycle pulse; begins fetch at start_addr.
- start_addr  in  ADDR_W  initial PC.
- jump_en  in  1  1-cycle pulse; redirect PC.
- jump_addr  in  ADDR_W  jump target.
- ram_addr  out  ADDR_W  opram read address.
- ram_ce  out  1  opram chip enable.
- ram_oce  out  1  opram output-register enable.
- ram_dout  in  DATA_W  opram read data.
- op_out  out  DATA_W  opcode to decode (FIFO head).
- op_pc  out  ADDR_W  address of op_out.
- op_valid  out  1  op_out/op_pc valid.
- op_ready  in  1  decode accepts when op_valid & op_ready.
- halted  out  1  HALT_OP consumed; fetch stopped.
- busy  out  1  state == FETCH.

Behaviour:
- Reset (rst=0, async): state IDLE, pc=0, ram_addr=0, ram_ce=0, ram_oce=0, op_out=0, op_pc=0, op_valid=0, halted=0, busy=0. FIFO emptied, in-flight pipe cleared, epoch=0.
- States:
  - IDLE: no reads; jump_en ignored. start → FETCH, pc=start_addr, FIFO flushed, halted=0.
  - FETCH: issues reads. A HALT_OP handshake → HALTED.
  - HALTED: halted=1, no reads. start → FETCH (as from IDLE).
- Issue rule in FETCH: issue a read this cycle iff fifo_count + inflight_count < FIFO_DEPTH.
  - On issue: ram_addr=pc (registered), ram_ce=1, ram_oce=1; pc <= pc+1, modulo 2^ADDR_W (0xFF wraps to 0x00).
  - No issue → ram_ce=0.
- Return pipe: RAM_LAT-deep shift register of {valid, epoch, pc}. At RAM_LAT cycles after issue, if valid and epoch == current epoch, push {ram_dout, pc} into FIFO. Stale-epoch entries are discarded.
- Overflow: the issue rule guarantees the FIFO never overflows. A push into a full FIFO is a design error; the bench asserts it never occurs.
- Output: op_valid = FIFO not empty; op_out/op_pc = FIFO head (first-word-fall-through).
  - Pop on op_valid & op_ready.
  - op_out/op_pc are stable while op_valid & !op_ready.
- Latency: start at cycle 0 → first op_valid at cycle 1+RAM_LAT (3 with defaults). Sustained throughput is 1 op/cycle with op_ready=1.
- Jump (FETCH only): pc <= jump_addr, epoch toggles, FIFO flushed, and no issue that cycle.
  - First target op is valid RAM_LAT+1 cycles after jump_en.
  - A pop in the same cycle as jump_en still completes; that op is delivered and not re-fetched.
- Halt:
  - When HALT_OP is popped: state → HALTED the next cycle; FIFO flushed, epoch toggles, issue stops.
  - Ops fetched after the halt word are never presented.
- Simultaneous events:
  - jump_en and a HALT_OP pop in the same cycle: halt wins and the jump is ignored.
  - start while in FETCH: ignored.
- rst asserted mid-operation: everything returns to reset values immediately, independent of clk.

Test Plan:
- Reset/idle: rst=0 then 1, no start → op_valid=0, ram_ce=0, halted=0, busy=0 for 20 cycles.
- Linear fetch: RAM[i]=i+0x10 for i<8, RAM[8]=0xFF; start with start_addr=0, op_ready=1.
  - First op_valid at cycle 3.
  - op_out sequence 0x10..0x17, then 0xFF; halted=1 on the next cycle.
- Backpressure: same program, op_ready toggling 1-0-0-1.
  - No op lost or duplicated; op_out stable while stalled.
  - fifo_count+inflight_count never exceeds 4.
- Jump flush: RAM[0x20]=0xA5; assert jump_en with jump_addr=0x20 while ops at pc 2..4 are in flight.
  - Next op after the jump is 0xA5 with op_pc=0x20, 3 cycles later.
  - Ops at pc 2..4 never appear.
- Wrap: start_addr=0xFE, RAM[0xFE]=1, RAM[0xFF]=2, RAM[0x00]=3 → op_pc 0xFE, 0xFF, 0x00 in order.
- Async reset mid-fetch: drop rst between clock edges → op_valid=0, ram_ce=0 immediately.
  - After release and start with start_addr=0, fetch restarts cleanly at op_pc=0.
